// File: rtl/axi_wr_slave_mem.sv
// AXI4 write-channel slave with a small internal word memory.
// Accepts one write transaction at a time (AW -> W beats -> B), applies WSTRB
// byte enables, flags illegal bursts (SLVERR) and out-of-range words (DECERR).
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   AW*                   write address channel (ID, addr, len, size, burst)
//   W*                    write data channel (data, strobes, last)
//   B*                    write response channel (resp, id)
//   dbg_addr/dbg_rdata    combinational word read of the memory
module axi_wr_slave_mem #(
    parameter int unsigned NUM_ID    = 4,
    parameter int unsigned DATA_LEN  = 32,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [31:0]                  AWADDR,
    input  logic [2:0]                   AWSIZE,
    input  logic [1:0]                   AWBURST,
    input  logic [NUM_ID-1:0]            AWID,
    input  logic [7:0]                   AWLEN,
    input  logic                         WVALID,
    output logic                         WREADY,
    input  logic [DATA_LEN-1:0]          WDATA,
    input  logic [DATA_LEN/8-1:0]        WSTRB,
    input  logic                         WLAST,
    output logic                         BVALID,
    input  logic                         BREADY,
    output logic [1:0]                   BRESP,
    output logic [NUM_ID-1:0]            BID,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
    output logic [DATA_LEN-1:0]          dbg_rdata
);

    localparam int unsigned NB     = DATA_LEN / 8;
    localparam int unsigned LOG_NB = $clog2(NB);
    localparam int unsigned AW     = $clog2(MEM_DEPTH);

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

    state_e              state_q, state_d;
    logic                awready_q, awready_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         base_q, base_d;
    logic [31:0]         mask_q, mask_d;
    logic [7:0]          len_q, len_d;
    logic [1:0]          burst_q, burst_d;
    logic [NUM_ID-1:0]   id_q, id_d;
    logic [7:0]          beat_q, beat_d;
    logic [1:0]          err_q, err_d;
    logic                suppress_q, suppress_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [NUM_ID-1:0]   bid_q, bid_d;

    logic [DATA_LEN-1:0] mem [MEM_DEPTH];

    logic [31:0] idx;
    logic        oob;
    logic        last_beat;
    logic        wr_en;
    logic [31:0] aw_mask;
    logic        wrap_len_ok;
    logic        illegal;
    logic [1:0]  err_beat;

    assign AWREADY   = awready_q;
    assign WREADY    = (state_q == StData);
    assign BVALID    = (state_q == StResp);
    assign BRESP     = bresp_q;
    assign BID       = bid_q;
    assign dbg_rdata = mem[dbg_addr];

    assign idx       = addr_q >> LOG_NB;
    assign oob       = (idx >= 32'(MEM_DEPTH));
    assign last_beat = (beat_q == len_q);
    assign wr_en     = WVALID && (state_q == StData) && !suppress_q && !oob;

    // Wrap region is (len+1)*NB bytes; only power-of-two lengths are legal, so a mask suffices.
    assign aw_mask = ((32'(AWLEN) + 32'd1) << LOG_NB) - 32'd1;

    always_comb begin
        wrap_len_ok = 1'b0;
        case (AWLEN)
            8'd1, 8'd3, 8'd7, 8'd15: wrap_len_ok = 1'b1;
            default:                 wrap_len_ok = 1'b0;
        endcase
        illegal = (AWSIZE != 3'(LOG_NB)) || (AWBURST == 2'b11) ||
                  ((AWBURST == BurstWrap) && !wrap_len_ok) ||
                  ((AWBURST == BurstWrap) && (AWADDR[LOG_NB-1:0] != '0));
    end

    // Error for the current beat: DECERR dominates, a WLAST mismatch raises to at least SLVERR.
    always_comb begin
        err_beat = err_q;
        if ((WLAST != last_beat) && (err_beat != RespDecerr)) begin
            err_beat = RespSlverr;
        end
        if (oob) begin
            err_beat = RespDecerr;
        end
    end

    always_comb begin
        state_d    = state_q;
        awready_d  = awready_q;
        addr_d     = addr_q;
        base_d     = base_q;
        mask_d     = mask_q;
        len_d      = len_q;
        burst_d    = burst_q;
        id_d       = id_q;
        beat_d     = beat_q;
        err_d      = err_q;
        suppress_d = suppress_q;
        bresp_d    = bresp_q;
        bid_d      = bid_q;
        case (state_q)
            StIdle: begin
                awready_d = 1'b1;
                if (AWVALID && awready_q) begin
                    awready_d  = 1'b0;
                    addr_d     = AWADDR;
                    base_d     = AWADDR & ~aw_mask;
                    mask_d     = aw_mask;
                    len_d      = AWLEN;
                    burst_d    = AWBURST;
                    id_d       = AWID;
                    beat_d     = 8'd0;
                    suppress_d = illegal;
                    err_d      = illegal ? RespSlverr : RespOkay;
                    state_d    = StData;
                end
            end
            StData: begin
                if (WVALID) begin
                    err_d  = err_beat;
                    beat_d = beat_q + 8'd1;
                    case (burst_q)
                        BurstFixed: addr_d = addr_q;
                        BurstIncr:  addr_d = addr_q + 32'(NB);
                        BurstWrap:  addr_d = base_q | ((addr_q + 32'(NB)) & mask_q);
                        default:    addr_d = addr_q;
                    endcase
                    if (last_beat) begin
                        bresp_d = err_beat;
                        bid_d   = id_q;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                if (BREADY) begin
                    awready_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= StIdle;
            awready_q  <= 1'b0;
            addr_q     <= '0;
            base_q     <= '0;
            mask_q     <= '0;
            len_q      <= '0;
            burst_q    <= '0;
            id_q       <= '0;
            beat_q     <= '0;
            err_q      <= RespOkay;
            suppress_q <= 1'b0;
            bresp_q    <= RespOkay;
            bid_q      <= '0;
        end else begin
            state_q    <= state_d;
            awready_q  <= awready_d;
            addr_q     <= addr_d;
            base_q     <= base_d;
            mask_q     <= mask_d;
            len_q      <= len_d;
            burst_q    <= burst_d;
            id_q       <= id_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
            suppress_q <= suppress_d;
            bresp_q    <= bresp_d;
            bid_q      <= bid_d;
        end
    end

    // Memory is never cleared; a beat coinciding with reset is dropped.
    always_ff @(posedge ACLK) begin
        if (wr_en && !ARESET) begin
            for (int i = 0; i < NB; i++) begin
                if (WSTRB[i]) begin
                    mem[idx[AW-1:0]][i*8 +: 8] <= WDATA[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_wr_slave_mem.sv
module tb_axi_wr_slave_mem;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic [3:0]  AWID;
    logic [7:0]  AWLEN;
    logic        WVALID;
    logic        WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;
    logic [3:0]  BID;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_rdata;

    int checks   = 0;
    int failures = 0;

    axi_wr_slave_mem #(.NUM_ID(4), .DATA_LEN(32), .MEM_DEPTH(256)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWID(AWID), .AWLEN(AWLEN),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_aw(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
        int n = 0;
        AWVALID = 1'b1; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWID = id;
        while (!AWREADY && n < 50) begin tick(); n++; end
        if (n >= 50) begin
            checks++; failures++;
            $display("FAIL aw_timeout: AWREADY stayed 0, required 1");
        end
        tick();
        AWVALID = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        WVALID = 1'b1; WDATA = data; WSTRB = strb; WLAST = last;
        while (!WREADY && n < 50) begin tick(); n++; end
        if (n >= 50) begin
            checks++; failures++;
            $display("FAIL w_timeout: WREADY stayed 0, required 1");
        end
        tick();
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp, output logic [3:0] id);
        int n = 0;
        BREADY = 1'b1;
        while (!BVALID && n < 50) begin tick(); n++; end
        if (n >= 50) begin
            checks++; failures++;
            $display("FAIL b_timeout: BVALID stayed 0, required 1");
        end
        resp = BRESP; id = BID;
        tick();
        BREADY = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        repeat (3) tick();
        checks++;
        if ({AWREADY, WREADY, BVALID, BRESP, BID} !== 9'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b required 0", {AWREADY, WREADY, BVALID, BRESP, BID});
        end
        ARESET = 1'b0;
        tick();
        checks++;
        if (AWREADY !== 1'b1) begin
            failures++;
            $display("FAIL reset_awready_after: got %b required 1", AWREADY);
        end
    endtask

    task automatic test_single();
        logic [1:0] r; logic [3:0] i;
        do_aw(32'h10, 8'd0, 3'd2, 2'b01, 4'd5);
        do_w(32'hDEADBEEF, 4'hF, 1'b1);
        wait_b(r, i);
        checks++;
        if (r !== 2'b00 || i !== 4'd5) begin
            failures++;
            $display("FAIL single_b: got resp=%b id=%0d required resp=00 id=5", r, i);
        end
        checks++;
        if (AWREADY !== 1'b1 || BVALID !== 1'b0) begin
            failures++;
            $display("FAIL single_awready_back: got AWREADY=%b BVALID=%b required 1 0", AWREADY, BVALID);
        end
        dbg_addr = 8'd4; #1;
        checks++;
        if (dbg_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_mem4: got %h required deadbeef", dbg_rdata);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] r; logic [3:0] i;
        logic [3:0]  strbs [4] = '{4'hF, 4'h1, 4'h0, 4'hC};
        logic [31:0] exp   [4] = '{32'h11223344, 32'h00000044, 32'h0, 32'h11220000};
        do_aw(32'h40, 8'd3, 3'd2, 2'b01, 4'd1);
        for (int k = 0; k < 4; k++) do_w(32'h0, 4'hF, k == 3);
        wait_b(r, i);
        do_aw(32'h40, 8'd3, 3'd2, 2'b01, 4'd2);
        for (int k = 0; k < 4; k++) do_w(32'h11223344, strbs[k], k == 3);
        wait_b(r, i);
        checks++;
        if (r !== 2'b00) begin
            failures++;
            $display("FAIL strobe_resp: got %b required 00", r);
        end
        for (int k = 0; k < 4; k++) begin
            dbg_addr = 8'(16 + k); #1;
            checks++;
            if (dbg_rdata !== exp[k]) begin
                failures++;
                $display("FAIL strobe_mem%0d: got %h required %h", 16 + k, dbg_rdata, exp[k]);
            end
        end
    endtask

    task automatic test_wrap_fixed();
        logic [1:0] r; logic [3:0] i;
        logic [7:0]  idxs [4] = '{8'd6, 8'd7, 8'd4, 8'd5};
        do_aw(32'h18, 8'd3, 3'd2, 2'b10, 4'd3);
        for (int k = 0; k < 4; k++) do_w(32'(k + 1), 4'hF, k == 3);
        wait_b(r, i);
        checks++;
        if (r !== 2'b00 || i !== 4'd3) begin
            failures++;
            $display("FAIL wrap_b: got resp=%b id=%0d required 00 3", r, i);
        end
        for (int k = 0; k < 4; k++) begin
            dbg_addr = idxs[k]; #1;
            checks++;
            if (dbg_rdata !== 32'(k + 1)) begin
                failures++;
                $display("FAIL wrap_mem%0d: got %h required %h", idxs[k], dbg_rdata, k + 1);
            end
        end
        do_aw(32'h8, 8'd2, 3'd2, 2'b00, 4'd4);
        do_w(32'hA, 4'hF, 1'b0);
        do_w(32'hB, 4'hF, 1'b0);
        do_w(32'hC, 4'hF, 1'b1);
        wait_b(r, i);
        dbg_addr = 8'd2; #1;
        checks++;
        if (dbg_rdata !== 32'hC || r !== 2'b00) begin
            failures++;
            $display("FAIL fixed_mem2: got %h resp=%b required 0000000c 00", dbg_rdata, r);
        end
    endtask

    task automatic test_errors();
        logic [1:0] r; logic [3:0] i;
        // Last word, second beat falls off the end.
        do_aw(32'h3FC, 8'd1, 3'd2, 2'b01, 4'd6);
        do_w(32'h55AA55AA, 4'hF, 1'b0);
        do_w(32'h12345678, 4'hF, 1'b1);
        wait_b(r, i);
        dbg_addr = 8'd255; #1;
        checks++;
        if (r !== 2'b11 || dbg_rdata !== 32'h55AA55AA) begin
            failures++;
            $display("FAIL decerr: got resp=%b mem255=%h required 11 55aa55aa", r, dbg_rdata);
        end
        // Bad AWSIZE must leave memory untouched.
        do_aw(32'h20, 8'd0, 3'd2, 2'b01, 4'd0);
        do_w(32'h0BADF00D, 4'hF, 1'b1);
        wait_b(r, i);
        do_aw(32'h20, 8'd0, 3'd1, 2'b01, 4'd0);
        do_w(32'hFFFFFFFF, 4'hF, 1'b1);
        wait_b(r, i);
        dbg_addr = 8'd8; #1;
        checks++;
        if (r !== 2'b10 || dbg_rdata !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL bad_size: got resp=%b mem8=%h required 10 0badf00d", r, dbg_rdata);
        end
        // Reserved burst type.
        do_aw(32'h20, 8'd0, 3'd2, 2'b11, 4'd0);
        do_w(32'h99999999, 4'hF, 1'b1);
        wait_b(r, i);
        dbg_addr = 8'd8; #1;
        checks++;
        if (r !== 2'b10 || dbg_rdata !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL bad_burst: got resp=%b mem8=%h required 10 0badf00d", r, dbg_rdata);
        end
        // Early WLAST: data still written, SLVERR reported.
        do_aw(32'h30, 8'd1, 3'd2, 2'b01, 4'd0);
        do_w(32'h111, 4'hF, 1'b1);
        do_w(32'h222, 4'hF, 1'b1);
        wait_b(r, i);
        checks++;
        if (r !== 2'b10) begin
            failures++;
            $display("FAIL early_wlast_resp: got %b required 10", r);
        end
        dbg_addr = 8'd12; #1;
        checks++;
        if (dbg_rdata !== 32'h111) begin
            failures++;
            $display("FAIL early_wlast_mem12: got %h required 00000111", dbg_rdata);
        end
        dbg_addr = 8'd13; #1;
        checks++;
        if (dbg_rdata !== 32'h222) begin
            failures++;
            $display("FAIL early_wlast_mem13: got %h required 00000222", dbg_rdata);
        end
    endtask

    task automatic test_backpressure();
        do_aw(32'h50, 8'd3, 3'd2, 2'b01, 4'd9);
        // A second AW is offered throughout and must not be taken.
        AWVALID = 1'b1; AWADDR = 32'h0; AWLEN = 8'd0;
        for (int k = 0; k < 4; k++) begin
            WVALID = 1'b0;
            tick();
            WVALID = 1'b1; WDATA = 32'(16'h100 + k); WSTRB = 4'hF; WLAST = (k == 3);
            tick();
            checks++;
            if (AWREADY !== 1'b0) begin
                failures++;
                $display("FAIL bp_awready_data%0d: got %b required 0", k, AWREADY);
            end
        end
        WVALID = 1'b0; WLAST = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (BVALID !== 1'b1 || BRESP !== 2'b00 || BID !== 4'd9 || AWREADY !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d: got BVALID=%b BRESP=%b BID=%0d AWREADY=%b required 1 00 9 0",
                         k, BVALID, BRESP, BID, AWREADY);
            end
            tick();
        end
        AWVALID = 1'b0;
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        checks++;
        if (BVALID !== 1'b0) begin
            failures++;
            $display("FAIL bp_bvalid_drop: got %b required 0", BVALID);
        end
        for (int k = 0; k < 4; k++) begin
            dbg_addr = 8'(20 + k); #1;
            checks++;
            if (dbg_rdata !== 32'(16'h100 + k)) begin
                failures++;
                $display("FAIL bp_mem%0d: got %h required %h", 20 + k, dbg_rdata, 16'h100 + k);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] r; logic [3:0] i;
        do_aw(32'h60, 8'd3, 3'd2, 2'b01, 4'd2);
        do_w(32'h201, 4'hF, 1'b0);
        do_w(32'h202, 4'hF, 1'b0);
        ARESET = 1'b1;
        tick();
        checks++;
        if ({AWREADY, WREADY, BVALID, BRESP, BID} !== 9'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got %b required 0", {AWREADY, WREADY, BVALID, BRESP, BID});
        end
        ARESET = 1'b0;
        tick();
        checks++;
        if (BVALID !== 1'b0 || WREADY !== 1'b0) begin
            failures++;
            $display("FAIL midreset_no_b: got BVALID=%b WREADY=%b required 0 0", BVALID, WREADY);
        end
        dbg_addr = 8'd24; #1;
        checks++;
        if (dbg_rdata !== 32'h201) begin
            failures++;
            $display("FAIL midreset_mem24: got %h required 00000201", dbg_rdata);
        end
        dbg_addr = 8'd25; #1;
        checks++;
        if (dbg_rdata !== 32'h202) begin
            failures++;
            $display("FAIL midreset_mem25: got %h required 00000202", dbg_rdata);
        end
        do_aw(32'h70, 8'd0, 3'd2, 2'b01, 4'd7);
        do_w(32'h77, 4'hF, 1'b1);
        wait_b(r, i);
        dbg_addr = 8'd28; #1;
        checks++;
        if (r !== 2'b00 || i !== 4'd7 || dbg_rdata !== 32'h77) begin
            failures++;
            $display("FAIL midreset_recover: got resp=%b id=%0d mem28=%h required 00 7 00000077",
                     r, i, dbg_rdata);
        end
    endtask

    initial begin
        ARESET = 1'b1; AWVALID = 1'b0; AWADDR = '0; AWSIZE = 3'd2; AWBURST = 2'b01;
        AWID = '0; AWLEN = '0; WVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0;
        BREADY = 1'b0; dbg_addr = '0;
        #1;
        test_reset();
        test_single();
        test_strobe();
        test_wrap_fixed();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_wr_slave_mem.md
Name: axi_wr_slave_mem

Overview:
AXI4 write-channel slave endpoint with a small internal word memory. It sits directly downstream of the AXI master interface and consumes the AW, W and B channels driven through the master driver clocking block. It handles one write transaction at a time and applies WSTRB byte enables. It returns BRESP/BID, so master-side sequences and scoreboards have a real target. A combinational debug read port lets the bench check memory contents.

Parameters:
NUM_ID, 4, width of AWID/BID
DATA_LEN, 32, data bus width in bits (32 or 64); bytes per beat NB = DATA_LEN/8
MEM_DEPTH, 256, number of DATA_LEN-bit words in memory

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  synchronous, active-high reset
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
AWADDR  in  32  byte start address
AWSIZE  in  3  beat size, log2 bytes
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
AWID  in  NUM_ID  transaction ID
AWLEN  in  8  beats minus one
WVALID  in  1  write data valid
WREADY  out  1  write data ready
WDATA  in  DATA_LEN  write data
WSTRB  in  DATA_LEN/8  byte enables
WLAST  in  1  last beat flag
BVALID  out  1  response valid
BREADY  in  1  response ready
BRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR
BID  out  NUM_ID  echoed AWID
dbg_addr  in  log2(MEM_DEPTH)  debug word index
dbg_rdata  out  DATA_LEN  mem[dbg_addr], combinational

Behaviour:
- Interface: one clock, ACLK; reset ARESET is synchronous and active-high.
- Reset values: AWREADY=0, WREADY=0, BVALID=0, BRESP=00, BID=0, FSM=IDLE. Memory contents are not cleared.
- Reset asserted mid-transaction: the transaction is aborted, no B is issued, and beats already written stay in memory.
- FSM states: IDLE, DATA, RESP.
- IDLE:
  - AWREADY=1 and WREADY=0. W beats offered before the AW handshake are not accepted.
  - On AWVALID&AWREADY: capture AWADDR, AWLEN, AWBURST, AWSIZE and AWID; clear the beat counter; set err=OKAY.
  - Move to DATA the next cycle. AWREADY drops in the same cycle as the move.
- Illegal-transaction checks, evaluated at AW capture. Any of the following sets err=SLVERR and suppresses all memory writes; the beats are still consumed:
  - AWSIZE != log2(NB)
  - AWBURST=11
  - WRAP with AWLEN not in {1,3,7,15}
  - WRAP with AWADDR not NB-aligned
- DATA:
  - WREADY=1.
  - Each WVALID&WREADY beat writes byte i of mem[idx] only where WSTRB[i]=1, with idx = cur_addr/NB.
  - Written data is visible on dbg_rdata the cycle after the handshake.
  - Beat with idx >= MEM_DEPTH: no write, and err is raised to DECERR. Error priority: DECERR > SLVERR > OKAY.
- Address update after each beat:
  - FIXED: unchanged.
  - INCR: cur_addr += NB, 32-bit wrap.
  - WRAP: region size W = (AWLEN+1)*NB; cur_addr = base + ((cur_addr + NB - base) mod W), with base = AWADDR aligned down to W.
- Burst termination is set by AWLEN: the final beat is beat number AWLEN, 0-indexed.
- WLAST checks: WLAST=1 on a non-final beat, or WLAST=0 on the final beat, raises err to at least SLVERR. The burst still ends on the AWLEN-counted beat.
- After the final beat handshake: WREADY=0 next cycle; FSM moves to RESP with BVALID=1, BRESP=err, BID=captured AWID.
- RESP:
  - BVALID, BRESP and BID are held stable until BREADY.
  - On BVALID&BREADY: BVALID=0 and FSM goes to IDLE, with AWREADY=1 the next cycle.
  - If BREADY is already high on the first RESP cycle, the handshake completes in that cycle.
- Throughput: minimum transaction is 1 AW cycle + (AWLEN+1) beat cycles + 1 B cycle. Only one transaction is outstanding at a time.
- WVALID may toggle freely in DATA; the beat counter advances only on handshake.

Test Plan:
- Reset, then single INCR (AWADDR=0x10, AWLEN=0, AWSIZE=2, WDATA=0xDEADBEEF, WSTRB=F, WLAST=1, BREADY=1) -> mem[4]=0xDEADBEEF; BRESP=00; BID=AWID; AWREADY back high 1 cycle after B.
- INCR AWLEN=3 at 0x40 with WSTRB sequence F,1,0,C over a pre-zeroed region -> mem[16..19] = full word, byte0 only, unchanged, bytes2-3 only; BRESP=00.
- WRAP AWLEN=3 at 0x18 (NB=4), data 1,2,3,4 -> mem[6]=1, mem[7]=2, mem[4]=3, mem[5]=4. Then FIXED AWLEN=2 at 0x8 -> mem[2] holds the last beat.
- Error cases:
  - AWADDR = MEM_DEPTH*NB - 4 with INCR AWLEN=1 -> last word written, second beat dropped, BRESP=11.
  - AWSIZE=1 -> no writes, BRESP=10.
  - WLAST high on beat 0 of AWLEN=1 -> both beats written, BRESP=10.
- Backpressure: WVALID toggled every other cycle, BREADY held low 5 cycles -> no AW accepted during DATA/RESP; BVALID/BRESP/BID stable until BREADY.
- ARESET pulsed mid-burst after 2 of 4 beats -> outputs at reset values next cycle, no B issued, first 2 words written; a new transaction then completes normally.
